// File: rtl/led_matrix_pwm_scan_if.sv
// led_matrix_pwm_scan_if: frame source and LED pin bundle for led_matrix_pwm_scan
interface led_matrix_pwm_scan_if #(
   parameter int NROW     = 4,
   parameter int NCOL     = 4,
   parameter int BRIGHT_W = 4
);
   logic [NROW*NCOL*BRIGHT_W-1:0] frame_data;
   logic                          frame_load;
   logic [NROW-1:0]               kled_tri;
   logic [NCOL-1:0]               aled;
   logic                          frame_start;
   logic                          load_pending;
   modport master (output frame_data, frame_load, input kled_tri, aled, frame_start, load_pending);
   modport slave  (input frame_data, frame_load, output kled_tri, aled, frame_start, load_pending);
endinterface

// File: rtl/led_matrix_pwm_scan.sv
// led_matrix_pwm_scan: one-LED-at-a-time PWM scanner with double-buffered frame; LED_SKIP_DARK_EN shortens dark slots to 1 clk
module led_matrix_pwm_scan #(
   parameter int NROW     = 4,
   parameter int NCOL     = 4,
   parameter int BRIGHT_W = 4,
   parameter int PRESCALE = 2,
   parameter int BLANK    = 1
) (
   input logic                clk,
   input logic                rst_n,
   led_matrix_pwm_scan_if.slave bus
);
   localparam int N  = NROW * NCOL;
   localparam int FW = N * BRIGHT_W;
   localparam int S  = BLANK + (1 << BRIGHT_W) - 1;
   localparam int PW = $clog2(PRESCALE + 1);
   localparam int SW = $clog2(S + 1);
   localparam int IW = $clog2(N + 1);
   logic [FW-1:0]       active_q, active_d, shadow_q, shadow_d;
   logic                pend_q, pend_d;
   logic [PW-1:0]       pre_q, pre_d;
   logic [SW-1:0]       step_q, step_d;
   logic [IW-1:0]       slot_q, slot_d;
   logic [NROW-1:0]     kled_q, kled_d;
   logic [NCOL-1:0]     aled_q, aled_d;
   logic                fs_q, fs_d;
   logic [BRIGHT_W-1:0] level;
   logic                off, dark, step_end, slot_end, wrap;
   // Scan counters, buffer swap at the frame wrap, and next output values decoded from the current slot
   always_comb begin
      level    = active_q[int'(slot_q)*BRIGHT_W +: BRIGHT_W];
      off      = level == '0;
`ifdef LED_SKIP_DARK_EN
      dark     = off;
`else
      dark     = 1'b0;
`endif
      step_end = int'(pre_q) == PRESCALE - 1;
      slot_end = dark || (step_end && int'(step_q) == S - 1);
      wrap     = slot_end && int'(slot_q) == N - 1;
      pre_d    = (step_end || dark) ? '0 : pre_q + 1'b1;
      step_d   = slot_end ? '0 : step_end ? step_q + 1'b1 : step_q;
      slot_d   = wrap ? '0 : slot_end ? slot_q + 1'b1 : slot_q;
      shadow_d = bus.frame_load ? bus.frame_data : shadow_q;
      active_d = !wrap ? active_q : bus.frame_load ? bus.frame_data : pend_q ? shadow_q : active_q;
      pend_d   = wrap ? 1'b0 : bus.frame_load ? 1'b1 : pend_q;
      fs_d     = slot_q == '0 && step_q == '0 && pre_q == '0;
      aled_d   = (off || int'(step_q) < BLANK) ? '1 : ~(NCOL'(1) << (int'(slot_q) % NCOL));
      kled_d   = (!off && int'(step_q) >= BLANK && int'(step_q) - BLANK < int'(level))
                 ? NROW'(1) << (int'(slot_q) / NCOL) : '0;
   end
   // State and registered outputs; reset forces the LED pins idle at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= '0;
         shadow_q <= '0;
         pend_q   <= 1'b0;
         pre_q    <= '0;
         step_q   <= '0;
         slot_q   <= '0;
         kled_q   <= '0;
         aled_q   <= '1;
         fs_q     <= 1'b0;
      end else begin
         active_q <= active_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
         pre_q    <= pre_d;
         step_q   <= step_d;
         slot_q   <= slot_d;
         kled_q   <= kled_d;
         aled_q   <= aled_d;
         fs_q     <= fs_d;
      end
   end
   assign bus.kled_tri     = kled_q;
   assign bus.aled         = aled_q;
   assign bus.frame_start  = fs_q;
   assign bus.load_pending = pend_q;
endmodule

// File: tb/tb_led_matrix_pwm_scan.sv
// tb_led_matrix_pwm_scan: frame-level scoreboard bench for led_matrix_pwm_scan (LED_SKIP_DARK_EN aware)
module tb_led_matrix_pwm_scan;
   localparam int NR = 4, NC = 4, BW = 4, PS = 2, BL = 1;
   localparam int N  = NR * NC;
   localparam int S  = BL + (1 << BW) - 1;
`ifdef LED_SKIP_DARK_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif
   typedef struct packed {
      int             len;
      int             act;
      int             bad;
      logic           pend;
      logic [N-1:0][7:0] on;
   } rec_t;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   fails  = 0;
   rec_t q[$];
   rec_t acc, e;
   bit   open = 1'b0;
   int   last, idx;
   logic [NR-1:0] k;
   logic [NC-1:0] a;
   logic [63:0] f_zero = 64'h0;
   logic [63:0] f_all  = 64'hFFFF_FFFF_FFFF_FFFF;
   logic [63:0] f_led5 = 64'h0000_0000_0070_0000;
   logic [63:0] f_junk = 64'h3333_3333_3333_3333;
   logic [63:0] f_ramp = 64'hFEDC_BA98_7654_3210;
   logic [63:0] f_led0 = 64'h0000_0000_0000_000F;
   led_matrix_pwm_scan_if #(.NROW(NR), .NCOL(NC), .BRIGHT_W(BW)) bus ();
   led_matrix_pwm_scan #(.NROW(NR), .NCOL(NC), .BRIGHT_W(BW), .PRESCALE(PS), .BLANK(BL)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   always #5 clk = ~clk;
   function automatic void chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endfunction
   function automatic rec_t expect_rec(input logic [63:0] f, input logic pend);
      rec_t r;
      r = '0;
      for (int i = 0; i < N; i++) begin
         int l;
         l = int'(f[i*BW +: BW]);
         r.on[i] = 8'(l * PS);
         r.act  += (l != 0) ? (S - BL) * PS : 0;
         r.len  += (SKIP && l == 0) ? 1 : S * PS;
      end
      r.pend = pend;
      return r;
   endfunction
   task automatic summary();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   endtask
   task automatic wait_fs();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.frame_start && n < 3000);
      if (!bus.frame_start) begin
         chk("frame_start_timeout", 0, 1);
         summary();
      end
   endtask
   task automatic load(input logic [63:0] f);
      bus.frame_data = f;
      bus.frame_load = 1'b1;
      @(negedge clk);
      bus.frame_load = 1'b0;
   endtask
   task automatic skip(input int n);
      repeat (n) @(negedge clk);
   endtask
   // monitor: accumulate one frame of pin activity, compare against the queued expectation at the next frame_start
   initial forever begin
      @(negedge clk);
      if (!rst_n) open = 1'b0;
      else begin
         if (bus.frame_start) begin
            if (open) begin
               if (q.size() == 0) chk("unexpected_frame", 1, 0);
               else begin
                  e = q.pop_front();
                  chk("frame_len", acc.len, e.len);
                  chk("aled_active", acc.act, e.act);
                  chk("onehot_order_bad", acc.bad, e.bad);
                  chk("load_pending_seen", int'(acc.pend), int'(e.pend));
                  for (int i = 0; i < N; i++) chk($sformatf("led%0d_on", i), int'(acc.on[i]), int'(e.on[i]));
               end
            end
            open = 1'b1;
            acc  = '0;
            last = -1;
         end
         if (open) begin
            k = bus.kled_tri;
            a = ~bus.aled;
            if (k != 0 && ($countones(k) != 1 || a == 0)) acc.bad++;
            if (a != 0) begin
               acc.act++;
               if ($countones(a) != 1) acc.bad++;
            end
            if ($countones(k) == 1 && $countones(a) == 1) begin
               idx = 0;
               for (int r = 0; r < NR; r++)
                  for (int c = 0; c < NC; c++)
                     if (k[r] && a[c]) idx = r * NC + c;
               acc.on[idx] = acc.on[idx] + 8'd1;
               if (idx < last) acc.bad++;
               last = idx;
            end
            if (bus.load_pending) acc.pend = 1'b1;
            acc.len++;
         end
      end
   end
   // stimulus: frame-synchronous loads, each displayed frame's expectation queued at its start
   initial begin
      int n;
      rst_n          = 1'b0;
      bus.frame_load = 1'b0;
      bus.frame_data = '0;
      skip(3);
      chk("rst_kled", int'(bus.kled_tri), 0);
      chk("rst_aled", int'(bus.aled), 15);
      chk("rst_fs", int'(bus.frame_start), 0);
      chk("rst_pend", int'(bus.load_pending), 0);
      rst_n = 1'b1;
      wait_fs(); q.push_back(expect_rec(f_zero, 1'b0));
      wait_fs(); q.push_back(expect_rec(f_zero, 1'b1)); skip(5); load(f_all);
      wait_fs(); q.push_back(expect_rec(f_all, 1'b1)); skip(10); load(f_led5);
      wait_fs(); q.push_back(expect_rec(f_led5, 1'b1)); skip(5); load(f_junk); skip(15); load(f_ramp);
      wait_fs(); q.push_back(expect_rec(f_ramp, 1'b0)); skip(expect_rec(f_ramp, 1'b0).len - 2); load(f_led0);
      wait_fs(); q.push_back(expect_rec(f_led0, 1'b0));
      wait_fs(); skip(10);
      chk("lit_before_rst_kled", int'(bus.kled_tri), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_kled", int'(bus.kled_tri), 0);
      chk("async_rst_aled", int'(bus.aled), 15);
      chk("async_rst_fs", int'(bus.frame_start), 0);
      chk("async_rst_pend", int'(bus.load_pending), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("fs_first_clk_after_rst", int'(bus.frame_start), 1);
      q.push_back(expect_rec(f_zero, 1'b0));
      wait_fs(); q.push_back(expect_rec(f_zero, 1'b0));
      n = 0;
      while (q.size() > 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drain", q.size(), 0);
      summary();
   end
endmodule
